// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared encodings and LFSR constants for mem_bus_responder
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    BURST_SINGLE = 2'b00,
    BURST_INCR   = 2'b01,
    BURST_WRAP   = 2'b10,
    BURST_RSVD   = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_XFER = 2'b10
  } state_t;

  // Galois form of the x^16+x^14+x^13+x^11+1 polynomial (taps 16,14,13,11)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_bus_responder_stall_lfsr.sv
// rtl/mem_bus_responder_stall_lfsr.sv - pseudo-random beat hold generator, built only with RANDOM_STALL_EN
`ifdef RANDOM_STALL_EN
module stall_lfsr
  import mem_bus_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic hold
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = lfsr_step(lfsr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= lfsr_nxt;
    end
  end

  // Hold decision for the cycle that follows the coming edge
  assign hold = adv ? lfsr_nxt[0] : lfsr[0];

endmodule
`endif

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - native-bus single-port memory responder (single/INCR/WRAP bursts)
// Optional RANDOM_STALL_EN inserts LFSR-driven gaps between beats.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int BURST_LEN   = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR,
  input  logic [1:0]  BURST,
  input  logic        REQ,
  input  logic        WRB,
  input  logic [31:0] WDATA,
  input  logic [3:0]  BSTROBE,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        STALL
);

  localparam logic [MEM_AW-1:0] WRAP_MASK = MEM_AW'(BURST_LEN - 1);

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  state_t            state;
  logic [MEM_AW-1:0] addr;
  burst_t            burst_q;
  logic              wr_q;
  logic [4:0]        beats;
  logic [3:0]        wcnt;
  logic              hold;
  logic [MEM_AW-1:0] addr_inc;
  logic [MEM_AW-1:0] addr_next;
  logic [MEM_AW-1:0] beat_addr;
  logic [MEM_AW-1:0] req_addr;
  logic              req_burst;
  logic              unused_addr_bits;

  assign req_addr         = ADDR[MEM_AW+1:2];
  assign req_burst        = (BURST == BURST_INCR) || (BURST == BURST_WRAP);
  assign unused_addr_bits = ^{ADDR[31:MEM_AW+2], ADDR[1:0]};

  always_comb begin
    addr_inc  = addr + 1'b1;
    addr_next = addr_inc;
    if (burst_q == BURST_WRAP) begin
      addr_next = (addr & ~WRAP_MASK) | (addr_inc & WRAP_MASK);
    end
    // A held XFER cycle re-presents the same beat
    beat_addr = ACK ? addr_next : addr;
  end

`ifdef RANDOM_STALL_EN
  stall_lfsr u_stall_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (state == ST_XFER),
    .hold (hold)
  );
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr    <= '0;
      burst_q <= BURST_SINGLE;
      wr_q    <= 1'b0;
      beats   <= '0;
      wcnt    <= '0;
      ACK     <= 1'b0;
      STALL   <= 1'b0;
      RDATA   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ) begin
            addr    <= req_addr;
            burst_q <= burst_t'(BURST);
            wr_q    <= WRB;
            beats   <= req_burst ? 5'(BURST_LEN) : 5'd1;
            STALL   <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
              wcnt  <= 4'(WAIT_CYCLES);
              ACK   <= 1'b0;
            end else begin
              state <= ST_XFER;
              ACK   <= !hold;
              if (!WRB && !hold) RDATA <= mem[req_addr];
            end
          end
        end
        ST_WAIT: begin
          if (wcnt == 4'd1) begin
            state <= ST_XFER;
            wcnt  <= '0;
            ACK   <= !hold;
            if (!wr_q && !hold) RDATA <= mem[addr];
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_XFER: begin
          if (ACK && beats == 5'd1) begin
            state <= ST_IDLE;
            beats <= '0;
            ACK   <= 1'b0;
            STALL <= 1'b0;
          end else begin
            if (ACK) begin
              addr  <= addr_next;
              beats <= beats - 5'd1;
            end
            ACK <= !hold;
            if (!wr_q && !hold) RDATA <= mem[beat_addr];
          end
        end
        default: begin
          state <= ST_IDLE;
          ACK   <= 1'b0;
          STALL <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset so contents survive rst; ACK is cleared by rst so no stray write
  always_ff @(posedge clk) begin
    if (ACK && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (BSTROBE[i]) mem[addr][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

  localparam int WAITC = 1;
  localparam int BLEN  = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ADDR;
  logic [1:0]  BURST;
  logic        REQ;
  logic        WRB;
  logic [31:0] WDATA;
  logic [3:0]  BSTROBE;
  logic [31:0] RDATA;
  logic        ACK;
  logic        STALL;

  mem_bus_responder #(.MEM_AW(12), .BURST_LEN(BLEN), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .BURST(BURST), .REQ(REQ), .WRB(WRB),
    .WDATA(WDATA), .BSTROBE(BSTROBE), .RDATA(RDATA), .ACK(ACK), .STALL(STALL)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [0:DEPTH-1];
  bit          known [0:DEPTH-1];
  logic [31:0] wd [0:BLEN-1];
  logic [3:0]  ws [0:BLEN-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int beat_word(input int s, input logic [1:0] bt, input int i);
    if (bt == 2'b01) return (s + i) % DEPTH;
    if (bt == 2'b10) return (s & ~(BLEN - 1)) | ((s + i) % BLEN);
    return s;
  endfunction

  // Called and returns at a falling edge
  task automatic run_xfer(input bit wr, input logic [31:0] a, input logic [1:0] bt,
                          input int abort_beat, input bit keep_req, input bit timed,
                          input string tag);
    int n, start, done, first_ack, last_ack, low, gaps, guard, wa;
    logic [31:0] last_exp;
    bit last_known;
    n = (bt == 2'b01 || bt == 2'b10) ? BLEN : 1;
    start = int'(a[13:2]);
    done = 0; first_ack = -1; last_ack = -1; low = -1; gaps = 0; guard = 0;
    last_known = 0; last_exp = '0;
    while (STALL !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq({tag, "_idle_timeout"}, 32'(STALL), 32'd0);
    ADDR = a; BURST = bt; WRB = wr; REQ = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!keep_req) REQ = 1'b0;
      if (ACK === 1'b1) begin
        if (STALL !== 1'b1) gaps++;
        wa = beat_word(start, bt, done);
        if (first_ack < 0) first_ack = c;
        last_ack = c;
        if (wr) begin
          WDATA = wd[done]; BSTROBE = ws[done];
          if (done == abort_beat) begin
            rst = 1'b1;
            #1;
            check_eq({tag, "_rst_ack"}, 32'(ACK), 32'd0);
            check_eq({tag, "_rst_stall"}, 32'(STALL), 32'd0);
            @(negedge clk);
            rst = 1'b0; REQ = 1'b0;
            return;
          end
          for (int b = 0; b < 4; b++)
            if (ws[done][b]) model[wa][8*b +: 8] = wd[done][8*b +: 8];
          if (ws[done] == 4'hF) known[wa] = 1;
        end else begin
          last_known = known[wa];
          last_exp = model[wa];
          if (known[wa]) check_eq({tag, "_rdata"}, RDATA, model[wa]);
        end
        done++;
      end else if (STALL !== 1'b1) begin
        low = c;
        break;
      end
    end
    REQ = 1'b0;
    check_eq({tag, "_acks"}, 32'(done), 32'(n));
    check_eq({tag, "_stall_gap"}, 32'(gaps), 32'd0);
    check_eq({tag, "_stall_drop"}, 32'(low), 32'(last_ack + 1));
    if (!wr && last_known) check_eq({tag, "_rdata_hold"}, RDATA, last_exp);
`ifndef RANDOM_STALL_EN
    if (timed) begin
      check_eq({tag, "_first_ack"}, 32'(first_ack), 32'(WAITC + 1));
      check_eq({tag, "_idle_cycle"}, 32'(low), 32'(WAITC + n + 1));
    end
`endif
  endtask

  task automatic set_data(input logic [31:0] base, input bit rnd);
    for (int i = 0; i < BLEN; i++) begin
      wd[i] = rnd ? $urandom : base + 32'(i);
      ws[i] = 4'hF;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  bt;
    bit          wr, kr;
    int          w;
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    rst = 1'b1; REQ = 1'b0; ADDR = '0; BURST = '0; WRB = 1'b0; WDATA = '0; BSTROBE = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ack", 32'(ACK), 32'd0);
    check_eq("reset_stall", 32'(STALL), 32'd0);
    check_eq("reset_rdata", RDATA, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preload, reset (contents must survive), then timed single read
    set_data(32'hDEADBEEF, 0);
    run_xfer(1, 32'h10, 2'b00, -1, 0, 1, "pre_deadbeef");
    set_data(32'hFFFFFFFF, 0);
    run_xfer(1, 32'h40, 2'b00, -1, 0, 0, "pre_ones");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_xfer(0, 32'h10, 2'b00, -1, 0, 1, "read_deadbeef");
    check_eq("deadbeef_value", RDATA, 32'hDEADBEEF);

    // Byte-strobe merge
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    run_xfer(1, 32'h40, 2'b00, -1, 0, 1, "strobe_wr");
    run_xfer(0, 32'h40, 2'b00, -1, 0, 1, "strobe_rd");
    check_eq("strobe_merge", RDATA, 32'hFF22FF44);

    // INCR across top of memory
    set_data(32'h0, 1);
    run_xfer(1, 32'h3FF8, 2'b01, -1, 0, 1, "incr_top_wr");
    run_xfer(0, 32'h3FF8, 2'b01, -1, 0, 1, "incr_top_rd");

    // WRAP write starting at word 6, verified with single reads
    set_data(32'd1, 0);
    run_xfer(1, 32'h18, 2'b10, -1, 0, 1, "wrap_wr");
    for (int i = 4; i < 8; i++) begin
      run_xfer(0, 32'(i * 4), 2'b00, -1, 0, 0, "wrap_rd");
      check_eq("wrap_word", RDATA, 32'((i == 4) ? 3 : (i == 5) ? 4 : (i == 6) ? 1 : 2));
    end

    // Reserved burst code behaves as single
    run_xfer(0, 32'h1C, 2'b11, -1, 0, 1, "rsvd_rd");

    // Reset during beat 2 of a 4-beat write
    set_data(32'hA0, 0);
    run_xfer(1, 32'h400, 2'b01, -1, 0, 0, "abort_pre");
    set_data(32'hB0, 0);
    run_xfer(1, 32'h400, 2'b01, 1, 0, 0, "abort_wr");
    run_xfer(0, 32'h400, 2'b01, -1, 0, 1, "abort_rd");
    check_eq("abort_last_untouched", RDATA, 32'hA3);

    // REQ held high throughout a burst read
    run_xfer(0, 32'h3FF8, 2'b01, -1, 1, 1, "keepreq_rd");

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      bt = 2'($urandom_range(0, 3));
      kr = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 63);
      a = (32'(w) << 2) | 32'($urandom_range(0, 3));
      for (int i = 0; i < BLEN; i++) begin
        wd[i] = $urandom;
        ws[i] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      end
      run_xfer(wr, a, bt, -1, kr, 1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
